// File: rtl/mjpg_stream_parser_if.sv
// Byte-stream bus between the MJPG encoder side and the stream parser.
// master drives the byte stream and observes results; slave is the parser.
interface mjpg_stream_parser_if #(
  parameter int unsigned DIM_W = 16
);
  logic             ivalid;
  logic [7:0]       ibyte;
  logic             ovalid;
  logic [7:0]       odata;
  logic             sof;
  logic             eof;
  logic             orst;
  logic             hdr_valid;
  logic [DIM_W-1:0] height;
  logic [DIM_W-1:0] width;
  logic             err;

  modport master (
    output ivalid, ibyte,
    input  ovalid, odata, sof, eof, orst, hdr_valid, height, width, err
  );

  modport slave (
    input  ivalid, ibyte,
    output ovalid, odata, sof, eof, orst, hdr_valid, height, width, err
  );
endinterface

// File: rtl/mjpg_stream_parser.sv
// MJPG stream parser: locks to SOI, walks marker segments, captures SOF0 frame size
// and strips 0xFF00 stuffing from scan data. Every output is registered.
module mjpg_stream_parser #(
  parameter int unsigned DIM_W       = 16,
  parameter bit          REQUIRE_SOF = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  mjpg_stream_parser_if.slave bus
);

  typedef enum logic [2:0] {HUNT, H_FF, H_CODE, LEN_H, LEN_L, BODY, SCAN, S_FF} state_t;

  state_t      state_q, state_d;
  logic        hunt_ff_q, hunt_ff_d;
  logic [7:0]  code_q, code_d;
  logic [7:0]  len_hi_q, len_hi_d;
  logic [15:0] remain_q, remain_d;
  logic [2:0]  off_q, off_d;
  logic        seen_sof_q, seen_sof_d;
  logic        sof_arm_q, sof_arm_d;
  logic        hdr_valid_q, hdr_valid_d;
  logic [15:0] height_q, height_d;
  logic [15:0] width_q, width_d;
  logic        ovalid_q, ovalid_d;
  logic [7:0]  odata_q, odata_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        orst_q, orst_d;
  logic        err_q, err_d;

  logic [7:0]  b;
  logic [15:0] len;
  logic        seg_end;

  assign b   = bus.ibyte;
  assign len = {len_hi_q, b};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      hunt_ff_q   <= 1'b0;
      code_q      <= '0;
      len_hi_q    <= '0;
      remain_q    <= '0;
      off_q       <= '0;
      seen_sof_q  <= 1'b0;
      sof_arm_q   <= 1'b0;
      hdr_valid_q <= 1'b0;
      height_q    <= '0;
      width_q     <= '0;
      ovalid_q    <= 1'b0;
      odata_q     <= '0;
      sof_q       <= 1'b0;
      eof_q       <= 1'b0;
      orst_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hunt_ff_q   <= hunt_ff_d;
      code_q      <= code_d;
      len_hi_q    <= len_hi_d;
      remain_q    <= remain_d;
      off_q       <= off_d;
      seen_sof_q  <= seen_sof_d;
      sof_arm_q   <= sof_arm_d;
      hdr_valid_q <= hdr_valid_d;
      height_q    <= height_d;
      width_q     <= width_d;
      ovalid_q    <= ovalid_d;
      odata_q     <= odata_d;
      sof_q       <= sof_d;
      eof_q       <= eof_d;
      orst_q      <= orst_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hunt_ff_d   = hunt_ff_q;
    code_d      = code_q;
    len_hi_d    = len_hi_q;
    remain_d    = remain_q;
    off_d       = off_q;
    seen_sof_d  = seen_sof_q;
    sof_arm_d   = sof_arm_q;
    hdr_valid_d = hdr_valid_q;
    height_d    = height_q;
    width_d     = width_q;
    odata_d     = odata_q;
    ovalid_d    = 1'b0;
    sof_d       = 1'b0;
    eof_d       = 1'b0;
    orst_d      = 1'b0;
    err_d       = 1'b0;
    seg_end     = 1'b0;

    if (bus.ivalid) begin
      unique case (state_q)
        HUNT: begin
          hunt_ff_d = (b == 8'hFF);
          if (hunt_ff_q && b == 8'hD8) begin
            state_d     = H_FF;
            hunt_ff_d   = 1'b0;
            seen_sof_d  = 1'b0;
            hdr_valid_d = 1'b0;
          end
        end
        H_FF: begin
          if (b == 8'hFF) state_d = H_CODE;
          else begin
            err_d   = 1'b1;
            state_d = HUNT;
          end
        end
        H_CODE: begin
          code_d = b;
          if (b == 8'hFF) begin
            state_d = H_CODE;
          end else if (b == 8'hD8) begin
            state_d     = H_FF;
            seen_sof_d  = 1'b0;
            hdr_valid_d = 1'b0;
          end else if (b == 8'hD9 || (b[7:4] == 4'hC && b[1:0] != 2'b00)) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else if (b == 8'h01 || b[7:3] == 5'b11010) begin
            state_d = H_FF;
          end else begin
            state_d = LEN_H;
          end
        end
        LEN_H: begin
          len_hi_d = b;
          state_d  = LEN_L;
        end
        LEN_L: begin
          if (len < 16'd2) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else if (len == 16'd2) begin
            seg_end = 1'b1;
          end else begin
            remain_d = len - 16'd2;
            off_d    = '0;
            state_d  = BODY;
          end
        end
        BODY: begin
          // SOF0 payload: offset 0 is precision, then Y hi/lo, X hi/lo
          if (code_q == 8'hC0) begin
            if (off_q == 3'd1) height_d[15:8] = b;
            if (off_q == 3'd2) height_d[7:0]  = b;
            if (off_q == 3'd3) width_d[15:8]  = b;
            if (off_q == 3'd4) width_d[7:0]   = b;
          end
          if (off_q != 3'd7) off_d = off_q + 3'd1;
          remain_d = remain_q - 16'd1;
          if (remain_q == 16'd1) seg_end = 1'b1;
        end
        SCAN: begin
          if (b == 8'hFF) begin
            state_d = S_FF;
          end else begin
            ovalid_d  = 1'b1;
            odata_d   = b;
            sof_d     = sof_arm_q;
            sof_arm_d = 1'b0;
          end
        end
        S_FF: begin
          if (b == 8'h00) begin
            ovalid_d  = 1'b1;
            odata_d   = 8'hFF;
            sof_d     = sof_arm_q;
            sof_arm_d = 1'b0;
            state_d   = SCAN;
          end else if (b == 8'hFF) begin
            state_d = S_FF;
          end else if (b[7:3] == 5'b11010) begin
            orst_d  = 1'b1;
            state_d = SCAN;
          end else if (b == 8'hD8) begin
            eof_d       = 1'b1;
            state_d     = H_FF;
            seen_sof_d  = 1'b0;
            hdr_valid_d = 1'b0;
          end else begin
            eof_d   = 1'b1;
            err_d   = (b != 8'hD9);
            state_d = HUNT;
          end
        end
      endcase

      if (seg_end) begin
        if (code_q == 8'hC0) seen_sof_d = 1'b1;
        if (code_q == 8'hDA) begin
          if (REQUIRE_SOF && !seen_sof_q) begin
            err_d   = 1'b1;
            state_d = HUNT;
          end else begin
            hdr_valid_d = 1'b1;
            sof_arm_d   = 1'b1;
            state_d     = SCAN;
          end
        end else begin
          state_d = H_FF;
        end
      end
    end
  end

  assign bus.ovalid    = ovalid_q;
  assign bus.odata     = odata_q;
  assign bus.sof       = sof_q;
  assign bus.eof       = eof_q;
  assign bus.orst      = orst_q;
  assign bus.err       = err_q;
  assign bus.hdr_valid = hdr_valid_q;
  assign bus.height    = DIM_W'(height_q);
  assign bus.width     = DIM_W'(width_q);

endmodule
